// File: rtl/sipo_pkg.sv
// Shared types for the sipo_deser deserializer.
// PAR stays in the encoding even when SIPO_PARITY_EN is not defined.
package sipo_pkg;

    localparam int SIPO_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } sipo_state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// N-bit MSB-first shift register with shift enable and synchronous active-low clear.
// next_o is the value the register takes at the coming edge.
module sipo_shift_reg #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         n_clr_i,
    input  logic         shift_en_i,
    input  logic         sin_i,
    output logic [N-1:0] next_o
);

    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (shift_en_i) begin
            shreg_d = {shreg_q[N-2:0], sin_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_clr_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Without a shift this is the held word, which the parity check relies on.
    assign next_o = shreg_d;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-cycle LOAD strobe for a downstream PIPO stage.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and the ERR strobe.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int N = SIPO_N_DEFAULT
) (
    input  logic         CLK,
    input  logic         n_Reset,
    input  logic         START,
    input  logic         SIN_VALID,
    input  logic         SIN,
    output logic [N-1:0] PO,
    output logic         LOAD,
    output logic         BUSY,
    output logic         ERR,
    output sipo_state_t  STATE
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    sipo_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  po_q;
    logic          load_q;
    logic          busy_q;
    logic          err_q;

    logic          shift_en;
    logic [N-1:0]  word_next;

    assign shift_en = (state_q == SHIFT) && SIN_VALID;

    sipo_shift_reg #(.N(N)) u_shreg (
        .clk_i      (CLK),
        .n_clr_i    (n_Reset),
        .shift_en_i (shift_en),
        .sin_i      (SIN),
        .next_o     (word_next)
    );

    always_ff @(posedge CLK) begin
        if (!n_Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            po_q    <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (SIN_VALID) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                            state_q <= PAR;
`else
                            state_q <= DONE;
                            po_q    <= word_next;
                            load_q  <= 1'b1;
                            busy_q  <= 1'b0;
`endif
                        end
                    end
                end
                PAR: begin
`ifdef SIPO_PARITY_EN
                    if (SIN_VALID) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if ((^{word_next, SIN}) == 1'b0) begin
                            po_q   <= word_next;
                            load_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                DONE: begin
                    if (START) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign PO    = po_q;
    assign LOAD  = load_q;
    assign BUSY  = busy_q;
    assign ERR   = err_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed frames plus random cycle-level stimulus
// compared every cycle against a bit-queue model. Honours SIPO_PARITY_EN.
module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int N = 8;
`ifdef SIPO_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int LAT = N + PAR_EN;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin = 1'b0;
    logic [N-1:0] po;
    logic         load;
    logic         busy;
    logic         err;
    sipo_state_t  dut_state;

    sipo_deser #(.N(N)) dut (
        .CLK       (clk),
        .n_Reset   (n_rst),
        .START     (start),
        .SIN_VALID (sin_valid),
        .SIN       (sin),
        .PO        (po),
        .LOAD      (load),
        .BUSY      (busy),
        .ERR       (err),
        .STATE     (dut_state)
    );

    // clock / cycle index
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 = waiting for START, 1 = collecting data bits, 2 = waiting for parity bit.
    int           m_phase = 0;
    bit           m_bits[$];
    logic [N-1:0] m_po = '0;
    logic         m_load = 1'b0;
    logic         m_err = 1'b0;

    function automatic logic [N-1:0] bits_to_word();
        int w = 0;
        for (int i = 0; i < N; i++) begin
            if (m_bits[i]) w += (1 << (N - 1 - i));
        end
        return w[N-1:0];
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            m_phase = 0;
            m_bits.delete();
            m_po   = '0;
            m_load = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_load = 1'b0;
            m_err  = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_bits.delete();
                end
                1: if (sin_valid) begin
                    m_bits.push_back(sin);
                    if (m_bits.size() == N) begin
                        if (PAR_EN != 0) begin
                            m_phase = 2;
                        end else begin
                            m_po    = bits_to_word();
                            m_load  = 1'b1;
                            m_phase = 0;
                        end
                    end
                end
                default: if (sin_valid) begin
                    int ones = int'(sin);
                    foreach (m_bits[i]) ones += int'(m_bits[i]);
                    if (ones % 2 == 0) begin
                        m_po   = bits_to_word();
                        m_load = 1'b1;
                    end else begin
                        m_err  = 1'b1;
                    end
                    m_phase = 0;
                end
            endcase
        end
    end

    // scoreboard / compare process
    bit   chk_en = 1'b0;
    logic prev_load = 1'b0;
    int   load_cnt = 0;
    int   err_cnt = 0;
    int   load_cycs[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("po", 32'(po), 32'(m_po));
            check("load", 32'(load), 32'(m_load));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("err", 32'(err), 32'(m_err));
            check("load_err_excl", 32'(load && err), 32'd0);
            check("load_back_to_back", 32'(load && prev_load), 32'd0);
            prev_load = load;
            if (load === 1'b1) begin
                load_cnt++;
                load_cycs.push_back(cyc);
            end
            if (err === 1'b1) err_cnt++;
        end
    end

    // driver tasks (called at a falling edge)
    int start_cyc = 0;

    task automatic drive(input logic s, input logic v, input logic d);
        if (s) start_cyc = cyc + 1;
        start     = s;
        sin_valid = v;
        sin       = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [N-1:0] w, input logic [N-1:0] stall_mask, input logic par_bit);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (stall_mask[N-1-i]) drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b1, w[N-1-i]);
        end
        if (PAR_EN != 0) drive(1'b0, 1'b1, par_bit);
        start     = 1'b0;
        sin_valid = 1'b0;
    endtask

    initial begin
        int lc0;
        int ec0;

        // reset held for two rising edges
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        check("rst_po", 32'(po), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dut_state), 32'(IDLE));
        chk_en = 1'b1;

        // basic frame
        lc0 = load_cnt;
        send_frame(8'b11010010, 8'b0, 1'b0);
        idle(2);
        check("basic_loads", 32'(load_cnt - lc0), 32'd1);
        check("basic_latency", 32'(load_cycs[$] - start_cyc), 32'(LAT));
        check("basic_po", 32'(po), 32'hD2);
        idle(10);
        check("hold_po", 32'(po), 32'hD2);
        check("hold_load", 32'(load), 32'd0);

        // three stall cycles
        lc0 = load_cnt;
        send_frame(8'b11010010, 8'b01010100, 1'b0);
        idle(2);
        check("stall_loads", 32'(load_cnt - lc0), 32'd1);
        check("stall_latency", 32'(load_cycs[$] - start_cyc), 32'(LAT + 3));
        check("stall_po", 32'(po), 32'hD2);

        // back-to-back frames, START in the DONE cycle
        lc0 = load_cnt;
        send_frame(8'b11010010, 8'b0, 1'b0);
        send_frame(8'b00000001, 8'b0, 1'b1);
        idle(2);
        check("b2b_loads", 32'(load_cnt - lc0), 32'd2);
        check("b2b_spacing", 32'(load_cycs[$] - load_cycs[load_cycs.size()-2]), 32'(N + 1 + PAR_EN));
        check("b2b_po", 32'(po), 32'h01);

        // reset after four bits
        lc0 = load_cnt;
        drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        check("midrst_state", 32'(dut_state), 32'(IDLE));
        check("midrst_po", 32'(po), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        idle(3);
        check("midrst_no_load", 32'(load_cnt - lc0), 32'd0);
        send_frame(8'hA5, 8'b0, 1'b0);
        idle(2);
        check("after_rst_po", 32'(po), 32'hA5);

`ifdef SIPO_PARITY_EN
        // good and bad parity bits
        lc0 = load_cnt;
        ec0 = err_cnt;
        send_frame(8'b11010010, 8'b0, 1'b0);
        idle(2);
        check("par_good_load", 32'(load_cnt - lc0), 32'd1);
        check("par_good_po", 32'(po), 32'hD2);
        send_frame(8'h3C, 8'b0, 1'b0);
        idle(2);
        lc0 = load_cnt;
        send_frame(8'b11010010, 8'b0, 1'b1);
        idle(2);
        check("par_bad_err", 32'(err_cnt - ec0), 32'd1);
        check("par_bad_no_load", 32'(load_cnt - lc0), 32'd0);
        check("par_bad_po_kept", 32'(po), 32'h3C);
`endif

        // random cycle-level stimulus, rare resets
        lc0 = load_cnt;
        ec0 = err_cnt;
        repeat (3000) begin
            n_rst     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 5) == 0);
            sin_valid = ($urandom_range(0, 3) != 0);
            sin       = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        n_rst = 1'b1;
        idle(5);
        check("random_loads_seen", 32'(load_cnt > lc0 + 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer that assembles an N-bit word from a bit-serial stream and presents it on a parallel bus with a one-cycle load strobe. Sits directly upstream of the N-bit enabled PIPO register stage: `PO` drives its data input and `LOAD` drives its enable, so each completed word is captured downstream exactly once.

## Interface
- `N`, 8, word width in bits; legal range N ≥ 2.
- `CLK`  input  1  rising-edge clock.
- `n_Reset`  input  1  synchronous reset, active-low; sampled on the rising edge of `CLK`.
- `START`  input  1  frame start request; honoured only in IDLE or DONE.
- `SIN_VALID`  input  1  `SIN` carries a valid bit this cycle.
- `SIN`  input  1  serial data bit, MSB first.
- `PO`  output  N  last completed word; holds until the next completed word.
- `LOAD`  output  1  one-cycle strobe that marks a new valid word on `PO`.
- `BUSY`  output  1  high in SHIFT and PAR.
- `ERR`  output  1  one-cycle parity-error strobe; constant 0 when parity is compiled out.

## Operation
- Reset (`n_Reset`=0 at a rising edge): state=IDLE, shift register=0, bit count=0, `PO`=0, `LOAD`=0, `BUSY`=0, `ERR`=0. Reset overrides every other input.
- IDLE: `START`=1 → SHIFT, count cleared. Otherwise stays in IDLE. `SIN_VALID` is ignored.
- SHIFT: on each cycle with `SIN_VALID`=1, shreg ← {shreg[N-2:0], `SIN`} and count ← count+1. Cycles with `SIN_VALID`=0 are stalls: no change, no timeout. When the Nth bit is accepted, state → PAR if parity is compiled in, otherwise → DONE. `START` is ignored in SHIFT.
- PAR: on the first cycle with `SIN_VALID`=1, `SIN` is taken as an even-parity bit. The XOR of the N data bits and `SIN` must equal 0. State → DONE.
- DONE (exactly one cycle): `PO` ← shreg and `LOAD`=1 if parity is good or compiled out. On a parity mismatch, `PO` is unchanged, `LOAD`=0 and `ERR`=1. Next state: SHIFT if `START`=1 in this cycle (back-to-back frames), else IDLE.
- Count width is $clog2(N+1). The count never wraps within a frame and is cleared on entering SHIFT.
- Reset mid-frame discards the partial word and leaves `PO`=0.

## Timing
- `START` sampled at edge k → SHIFT from k. Data bits are accepted at edges k+1…k+N when `SIN_VALID` is held high.
- No parity: DONE follows edge k+N. `LOAD`=1 and the new `PO` are both visible in the cycle after edge k+N; `PO` is registered and updated at edge k+N.
- Parity: the parity bit is taken at edge k+N+1, and `LOAD` or `ERR` is visible in the cycle after it.
- Each stall cycle adds exactly one cycle of latency.
- `LOAD` is never high for two consecutive cycles. `LOAD` and `ERR` are never high together.
- Downstream captures `PO` at the first rising edge where `LOAD`=1.

## Configuration
- `SIPO_PARITY_EN` defined: the PAR state and `ERR` logic are compiled in. A frame is N data bits plus 1 even-parity bit.
- `SIPO_PARITY_EN` undefined: there is no PAR state, `ERR` is tied to 0, and a frame is N bits.

## Structure
- `sipo_pkg`: the state enum `sipo_state_t` {IDLE, SHIFT, PAR, DONE}. PAR stays in the enum unconditionally to keep one encoding.
- Sub-module `sipo_shift_reg`: the N-bit shift register with shift-enable and synchronous active-low clear.
- The top level owns the FSM, the bit counter, the `PO` register and the strobes.

## Test plan
- Reset: hold `n_Reset`=0 for 2 edges, then release → `PO`=0, `LOAD`=0, `BUSY`=0, `ERR`=0.
- Basic frame, N=8: `START`, then bits 1,1,0,1,0,0,1,0 with `SIN_VALID`=1 → exactly one `LOAD` pulse N+1 cycles after `START`, `PO`=8'b11010010. `PO` must still read 8'b11010010 with `LOAD`=0 ten cycles later.
- Stalls: the same word with `SIN_VALID`=0 on 3 interleaved cycles → `LOAD` 3 cycles later than in the basic frame, `PO`=8'b11010010.
- Back-to-back: `START` asserted in the DONE cycle, second word 8'b00000001 → two `LOAD` pulses 9 cycles apart, `PO`=8'b00000001 after the second.
- Reset mid-frame: assert `n_Reset`=0 after 4 bits → state IDLE, `PO`=0, no `LOAD`. A following full frame 8'hA5 → `PO`=8'hA5.
- `SIPO_PARITY_EN`: 8'b11010010 with parity bit 0 → `LOAD`=1, `PO`=8'b11010010. The same word with parity bit 1 → `ERR`=1 for one cycle, `LOAD`=0, `PO` unchanged.
